fetch_unit: RTL and testbench

Instruction-fetch stage of the RISC-V pipeline. Holds the fetch PC, issues in-order requests to instruction memory over a ready/valid handshake, and buffers returned instructions with their PC and prediction bit until decode consumes them. It sits directly upstream of `branch_prediction`:
- it provides `pc_F` and `pc4`;
- it consumes `pc_next`, `taken_F`, `flush` and `pc_restore`;
- it feeds the IF/ID operands (`pc_D`, `pc4_D`, `taken_D`) to decode.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_unit.sv | 73 +++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage types and constants (XLEN, PC_STEP, fetch_entry_t)
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            taken;
    logic            filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order fetch buffer; alloc at tail, fill oldest unfilled, pop head, clear all; outputs head entry, count, unfilled
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic [XLEN-1:0]          alloc_pc4,
  input  logic                     alloc_taken,
  input  logic                     fill,
  input  logic [XLEN-1:0]          fill_data,
  input  logic                     pop,
  input  logic                     clear,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   unfilled
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [AW:0] head_q, head_d, tail_q, tail_d, fptr_q, fptr_d;
  always_comb begin
    mem_d = mem_q;
    if (alloc) mem_d[tail_q[AW-1:0]] = '{pc: alloc_pc, pc4: alloc_pc4, instr: '0, taken: alloc_taken, filled: 1'b0};
    if (fill) begin
      mem_d[fptr_q[AW-1:0]].instr  = fill_data;
      mem_d[fptr_q[AW-1:0]].filled = 1'b1;
    end
    head_d = clear ? '0 : head_q + (AW+1)'(pop);
    tail_d = clear ? '0 : tail_q + (AW+1)'(alloc);
    fptr_d = clear ? '0 : fptr_q + (AW+1)'(fill);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      fptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      fptr_q <= fptr_d;
    end
  end
  assign head     = mem_q[head_q[AW-1:0]];
  assign count    = tail_q - head_q;
  assign unfilled = tail_q - fptr_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC register, stale-response drop counter and imem handshake; ports: predictor (pc_F/pc4/pc_next/taken_F/flush/pc_restore), imem req/rsp, decode (*_D, stall_D)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc_F,
  output logic [XLEN-1:0] pc4,
  input  logic [XLEN-1:0] pc_next,
  input  logic            taken_F,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_restore,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            stall_D,
  output logic            valid_D,
  output logic [XLEN-1:0] instr_D,
  output logic [XLEN-1:0] pc_D,
  output logic [XLEN-1:0] pc4_D,
  output logic            taken_D
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d, count, unfilled;
  logic            accept, fill;
  fetch_entry_t    head;
  assign imem_req_valid = !rst && ({1'b0, count} + {1'b0, drop_q} < (CW+1)'(DEPTH));
  assign accept         = imem_req_valid && imem_req_ready;
  assign fill           = imem_rsp_valid && drop_q == '0 && !flush;
  always_comb begin
    pc_d   = flush ? pc_restore : accept ? pc_next : pc_q;
    drop_d = flush ? drop_q + unfilled + CW'(accept) - CW'(imem_rsp_valid)
                   : drop_q - CW'(imem_rsp_valid && drop_q != '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .alloc       (accept && !flush),
    .alloc_pc    (pc_q),
    .alloc_pc4   (pc4),
    .alloc_taken (taken_F),
    .fill        (fill),
    .fill_data   (imem_rsp_data),
    .pop         (valid_D && !stall_D && !flush),
    .clear       (flush),
    .head        (head),
    .count       (count),
    .unfilled    (unfilled)
  );
  assign pc_F          = pc_q;
  assign pc4           = pc_q + PC_STEP;
  assign imem_req_addr = pc_q;
  assign valid_D       = count != '0 && head.filled;
  assign instr_D       = head.instr;
  assign pc_D          = head.pc;
  assign pc4_D         = head.pc4;
  assign taken_D       = head.taken;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios against fetch_unit with an in-order instruction memory responder
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, flush, imem_req_ready, imem_rsp_valid, stall_D;
  logic [31:0] pc_restore, imem_rsp_data;
  logic [31:0] pc_F, pc4, pc_next, imem_req_addr, instr_D, pc_D, pc4_D;
  logic        taken_F, imem_req_valid, valid_D, taken_D;
  int          n_cmp = 0, n_bad = 0, lat = 1, cyc = 0;
  typedef struct {logic [31:0] addr; int t;} req_t;
  req_t q[$];

  always #5 clk = ~clk;
  assign pc_next = pc4;
  assign taken_F = pc_F[2];

  fetch_unit #(.RESET_PC(32'h100), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_F(pc_F), .pc4(pc4), .pc_next(pc_next), .taken_F(taken_F),
    .flush(flush), .pc_restore(pc_restore), .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .stall_D(stall_D),
    .valid_D(valid_D), .instr_D(instr_D), .pc_D(pc_D), .pc4_D(pc4_D), .taken_D(taken_D)
  );

  // In-order memory: returns ~addr, sampled by the DUT lat edges after acceptance
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) q.push_back('{imem_req_addr, cyc});
      if (q.size() > 0 && cyc - q[0].t >= lat - 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= ~q[0].addr;
        q.pop_front();
      end else imem_rsp_valid <= 1'b0;
    end
    cyc = cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset(input int l);
    rst = 1'b1; flush = 1'b0; stall_D = 1'b0; imem_req_ready = 1'b1; pc_restore = '0; lat = l;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1);
    #1;
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL reset req_after_release: got %b want 1", imem_req_valid); end
    stall_D = 1'b1;
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (pc_F !== 32'h100) begin n_bad++; $display("FAIL reset pc_F: got %h want 00000100", pc_F); end
    n_cmp++; if ({valid_D, imem_req_valid} !== 2'b00) begin n_bad++; $display("FAIL reset valid: got %b want 00", {valid_D, imem_req_valid}); end
    n_cmp++; if ({instr_D, pc_D, pc4_D, taken_D} !== '0) begin n_bad++; $display("FAIL reset fields: got %h %h %h %b want 0", instr_D, pc_D, pc4_D, taken_D); end
    @(negedge clk);
    rst = 1'b0; stall_D = 1'b0;
    #1;
    n_cmp++; if ({imem_req_valid, valid_D, pc_F} !== {2'b10, 32'h100}) begin n_bad++; $display("FAIL reset release: got req=%b v=%b pc=%h want 1 0 00000100", imem_req_valid, valid_D, pc_F); end
  endtask

  task automatic test_stream();
    bit          ev[7]  = '{0, 1, 1, 0, 1, 1, 0};
    logic [31:0] epd[7] = '{0, 'h100, 'h104, 0, 'h108, 'h10C, 0};
    bit          erq[7] = '{1, 0, 1, 1, 0, 1, 1};
    logic [31:0] epf[7] = '{'h104, 'h108, 'h108, 'h10C, 'h110, 'h110, 'h114};
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_cmp++; if (valid_D !== ev[i]) begin n_bad++; $display("FAIL stream valid_D E%0d: got %b want %b", i+1, valid_D, ev[i]); end
      if (ev[i]) begin n_cmp++; if ({pc_D, pc4_D, instr_D, taken_D} !== {epd[i], epd[i] + 32'd4, ~epd[i], epd[i][2]}) begin n_bad++; $display("FAIL stream entry E%0d: got pc=%h pc4=%h ins=%h t=%b want pc=%h", i+1, pc_D, pc4_D, instr_D, taken_D, epd[i]); end end
      n_cmp++; if (imem_req_valid !== erq[i]) begin n_bad++; $display("FAIL stream req E%0d: got %b want %b", i+1, imem_req_valid, erq[i]); end
      n_cmp++; if (pc_F !== epf[i]) begin n_bad++; $display("FAIL stream pc_F E%0d: got %h want %h", i+1, pc_F, epf[i]); end
    end
  endtask

  task automatic test_ready_stall();
    bit          rd[7]  = '{1, 0, 0, 0, 1, 1, 1};
    bit          ev[7]  = '{0, 1, 0, 0, 0, 1, 1};
    logic [31:0] epd[7] = '{0, 'h100, 0, 0, 0, 'h104, 'h108};
    logic [31:0] epf[7] = '{'h104, 'h104, 'h104, 'h104, 'h108, 'h10C, 'h10C};
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      imem_req_ready = rd[i];
      @(negedge clk);
      n_cmp++; if (valid_D !== ev[i]) begin n_bad++; $display("FAIL ready valid_D E%0d: got %b want %b", i+1, valid_D, ev[i]); end
      if (ev[i]) begin n_cmp++; if ({pc_D, instr_D} !== {epd[i], ~epd[i]}) begin n_bad++; $display("FAIL ready entry E%0d: got pc=%h ins=%h want pc=%h", i+1, pc_D, instr_D, epd[i]); end end
      n_cmp++; if (pc_F !== epf[i]) begin n_bad++; $display("FAIL ready pc_F E%0d: got %h want %h", i+1, pc_F, epf[i]); end
    end
  endtask

  task automatic test_flush();
    bit          fl[9]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    bit          ev[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    logic [31:0] epd[9] = '{0, 0, 0, 0, 0, 0, 0, 'h200, 'h204};
    bit          erq[9] = '{1, 0, 0, 1, 1, 0, 0, 0, 1};
    logic [31:0] epf[9] = '{'h104, 'h108, 'h200, 'h200, 'h204, 'h208, 'h208, 'h208, 'h208};
    do_reset(3);
    pc_restore = 32'h200;
    for (int i = 0; i < 9; i++) begin
      flush = fl[i];
      @(negedge clk);
      n_cmp++; if (valid_D !== ev[i]) begin n_bad++; $display("FAIL flush valid_D E%0d: got %b want %b", i+1, valid_D, ev[i]); end
      if (ev[i]) begin n_cmp++; if ({pc_D, instr_D} !== {epd[i], ~epd[i]}) begin n_bad++; $display("FAIL flush entry E%0d: got pc=%h ins=%h want pc=%h", i+1, pc_D, instr_D, epd[i]); end end
      n_cmp++; if (imem_req_valid !== erq[i]) begin n_bad++; $display("FAIL flush req E%0d: got %b want %b", i+1, imem_req_valid, erq[i]); end
      n_cmp++; if (pc_F !== epf[i]) begin n_bad++; $display("FAIL flush pc_F E%0d: got %h want %h", i+1, pc_F, epf[i]); end
    end
  endtask

  task automatic test_flush_same_cycle();
    bit          fl[5]  = '{0, 1, 0, 0, 0};
    bit          ev[5]  = '{0, 0, 0, 1, 1};
    logic [31:0] epd[5] = '{0, 0, 0, 'h200, 'h204};
    bit          erq[5] = '{1, 1, 1, 0, 1};
    logic [31:0] epf[5] = '{'h104, 'h200, 'h204, 'h208, 'h208};
    do_reset(1);
    pc_restore = 32'h200;
    for (int i = 0; i < 5; i++) begin
      flush = fl[i];
      @(negedge clk);
      n_cmp++; if (valid_D !== ev[i]) begin n_bad++; $display("FAIL flush_same valid_D E%0d: got %b want %b", i+1, valid_D, ev[i]); end
      if (ev[i]) begin n_cmp++; if ({pc_D, instr_D} !== {epd[i], ~epd[i]}) begin n_bad++; $display("FAIL flush_same entry E%0d: got pc=%h ins=%h want pc=%h", i+1, pc_D, instr_D, epd[i]); end end
      n_cmp++; if (imem_req_valid !== erq[i]) begin n_bad++; $display("FAIL flush_same req E%0d: got %b want %b", i+1, imem_req_valid, erq[i]); end
      n_cmp++; if (pc_F !== epf[i]) begin n_bad++; $display("FAIL flush_same pc_F E%0d: got %h want %h", i+1, pc_F, epf[i]); end
    end
  endtask

  task automatic test_full_stall();
    bit          st[7]  = '{1, 1, 1, 1, 0, 0, 0};
    bit          ev[7]  = '{0, 1, 1, 1, 1, 0, 1};
    logic [31:0] epd[7] = '{0, 'h100, 'h100, 'h100, 'h104, 0, 'h108};
    bit          erq[7] = '{1, 0, 0, 0, 1, 1, 0};
    logic [31:0] epf[7] = '{'h104, 'h108, 'h108, 'h108, 'h108, 'h10C, 'h110};
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      stall_D = st[i];
      if (i == 4) begin
        #1;
        n_cmp++; if ({imem_req_valid, valid_D} !== 2'b01) begin n_bad++; $display("FAIL full_stall release_req: got req=%b v=%b want 0 1", imem_req_valid, valid_D); end
      end
      @(negedge clk);
      n_cmp++; if (valid_D !== ev[i]) begin n_bad++; $display("FAIL full_stall valid_D E%0d: got %b want %b", i+1, valid_D, ev[i]); end
      if (ev[i]) begin n_cmp++; if ({pc_D, instr_D} !== {epd[i], ~epd[i]}) begin n_bad++; $display("FAIL full_stall entry E%0d: got pc=%h ins=%h want pc=%h", i+1, pc_D, instr_D, epd[i]); end end
      n_cmp++; if (imem_req_valid !== erq[i]) begin n_bad++; $display("FAIL full_stall req E%0d: got %b want %b", i+1, imem_req_valid, erq[i]); end
      n_cmp++; if (pc_F !== epf[i]) begin n_bad++; $display("FAIL full_stall pc_F E%0d: got %h want %h", i+1, pc_F, epf[i]); end
    end
  endtask

  task automatic test_wrap();
    do_reset(1);
    imem_req_ready = 1'b0; flush = 1'b1; pc_restore = 32'hFFFF_FFFC;
    @(negedge clk);
    n_cmp++; if ({pc_F, pc4} !== {32'hFFFF_FFFC, 32'h0}) begin n_bad++; $display("FAIL wrap pc4: got pc=%h pc4=%h want fffffffc 00000000", pc_F, pc4); end
    flush = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({pc_F, pc4} !== {32'h0, 32'h4}) begin n_bad++; $display("FAIL wrap next: got pc=%h pc4=%h want 00000000 00000004", pc_F, pc4); end
    @(negedge clk);
    n_cmp++; if ({valid_D, pc_D, pc4_D, instr_D, taken_D} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h3, 1'b1}) begin n_bad++; $display("FAIL wrap entry: got v=%b pc=%h pc4=%h ins=%h t=%b want 1 fffffffc 00000000 00000003 1", valid_D, pc_D, pc4_D, instr_D, taken_D); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_ready_stall();
    test_flush();
    test_flush_same_cycle();
    test_full_stall();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
